lru_ctrl: RTL and testbench

// - Sequences and shares the 8-entry x 1-bit LRU bit array of the 2-way set-associative cache

---
 rtl/lru_pkg.sv | 27 ++
 rtl/lru_ctrl_if.sv | 30 +++
 rtl/lru_ctrl_rr_arb2.sv | 33 +++
 rtl/lru_ctrl.sv | 125 ++++++++++++
 tb/tb_lru_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lru_pkg.sv
// Shared types and helpers for the LRU-bit controller of the 2-way cache.
package lru_pkg;

  localparam int LRU_IDX_W    = 3;
  localparam int LRU_NUM_SETS = 1 << LRU_IDX_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} lru_state_t;
  typedef enum logic {OP_TOUCH = 1'b0, OP_VICTIM = 1'b1} lru_op_t;

  // New LRU bit: the accessed way becomes MRU, so the other way is stored.
  function automatic logic lru_fill(input lru_op_t op, input logic way, input logic cur);
    if (op == OP_VICTIM) begin
      lru_fill = ~cur;
    end else begin
      lru_fill = ~way;
    end
  endfunction

  function automatic logic lru_rsp_way(input lru_op_t op, input logic way, input logic cur);
    if (op == OP_VICTIM) begin
      lru_rsp_way = cur;
    end else begin
      lru_rsp_way = way;
    end
  endfunction

endpackage

// File: rtl/lru_ctrl_if.sv
// Request/response bundle for the two requesters (I-side = 0, D-side = 1).
interface lru_ctrl_if import lru_pkg::*; #(parameter int IDX_W = LRU_IDX_W) ();

  logic             req0_valid;
  logic             req0_ready;
  lru_op_t          req0_op;
  logic [IDX_W-1:0] req0_ix;
  logic             req0_way;
  logic             req1_valid;
  logic             req1_ready;
  lru_op_t          req1_op;
  logic [IDX_W-1:0] req1_ix;
  logic             req1_way;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             rsp_way;

  modport master (
    output req0_valid, req0_op, req0_ix, req0_way,
    output req1_valid, req1_op, req1_ix, req1_way,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_way
  );

  modport slave (
    input  req0_valid, req0_op, req0_ix, req0_way,
    input  req1_valid, req1_op, req1_ix, req1_way,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_way
  );

endinterface

// File: rtl/lru_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester preferred on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_ptr_r;

  // One-hot grant from the valids and the preference pointer.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After a grant the other requester becomes preferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= 1'b0;
    end else if (|grant) begin
      rr_ptr_r <= ~grant[1];
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/lru_ctrl.sv
// LRU bit-array sequencer: clear sweep after reset/flush, then one arbitrated
// TOUCH/VICTIM per cycle with a registered response one cycle later.
module lru_ctrl import lru_pkg::*; #(
  parameter int IDX_W = LRU_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             init_done,
  lru_ctrl_if.slave        bus,
  output logic             arr_we,
  output logic [IDX_W-1:0] arr_ix,
  output logic             arr_din,
  input  logic             arr_dout
);

  localparam int               NUM_SETS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IX  = IDX_W'(NUM_SETS - 1);

  lru_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] init_cnt_r, init_cnt_nxt_s;
  logic             run_s;
  logic [1:0]       valid_s, grant_s;
  lru_op_t          sel_op_s;
  logic [IDX_W-1:0] sel_ix_s;
  logic             sel_way_s;
  logic             rsp0_r, rsp1_r, rsp_way_r;

  assign run_s   = (state_r == ST_RUN);
  assign valid_s = {bus.req1_valid, bus.req0_valid} & {2{run_s}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid_s),
    .grant (grant_s)
  );

  assign sel_op_s  = grant_s[1] ? bus.req1_op  : bus.req0_op;
  assign sel_ix_s  = grant_s[1] ? bus.req1_ix  : bus.req0_ix;
  assign sel_way_s = grant_s[1] ? bus.req1_way : bus.req0_way;

  // Next state and sweep counter; flush always restarts the sweep at set 0.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    case (state_r)
      ST_INIT: begin
        if (flush) begin
          init_cnt_nxt_s = '0;
        end else if (init_cnt_r == LAST_IX) begin
          state_nxt_s    = ST_RUN;
          init_cnt_nxt_s = '0;
        end else begin
          init_cnt_nxt_s = init_cnt_r + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt_s    = ST_INIT;
          init_cnt_nxt_s = '0;
        end else begin
          state_nxt_s    = ST_RUN;
        end
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_cnt_nxt_s = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
    end
  end

  // Array port mux: sweep clear, granted update, or idle read of req0_ix.
  always_comb begin
    arr_we  = 1'b0;
    arr_ix  = bus.req0_ix;
    arr_din = 1'b0;
    if (!run_s) begin
      arr_we = 1'b1;
      arr_ix = init_cnt_r;
    end else if (|grant_s) begin
      arr_we  = 1'b1;
      arr_ix  = sel_ix_s;
      arr_din = lru_fill(sel_op_s, sel_way_s, arr_dout);
    end else begin
      arr_we = 1'b0;
    end
  end

  // Response registers; rsp_way keeps its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_r    <= 1'b0;
      rsp1_r    <= 1'b0;
      rsp_way_r <= 1'b0;
    end else begin
      rsp0_r <= grant_s[0];
      rsp1_r <= grant_s[1];
      if (|grant_s) begin
        rsp_way_r <= lru_rsp_way(sel_op_s, sel_way_s, arr_dout);
      end else begin
        rsp_way_r <= rsp_way_r;
      end
    end
  end

  assign bus.req0_ready = grant_s[0];
  assign bus.req1_ready = grant_s[1];
  assign bus.rsp0_valid = rsp0_r;
  assign bus.rsp1_valid = rsp1_r;
  assign bus.rsp_way    = rsp_way_r;
  assign init_done      = run_s;

endmodule

// File: tb/tb_lru_ctrl.sv
// Directed bench for lru_ctrl with a behavioural 8x1 LRU array attached.
module tb_lru_ctrl;
  import lru_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       init_done;
  logic       arr_we;
  logic [2:0] arr_ix;
  logic       arr_din;
  logic       arr_dout;
  logic [7:0] mem = 8'hFF;
  int         n_cmp = 0;
  int         n_err = 0;

  lru_ctrl_if #(.IDX_W(3)) bus ();

  lru_ctrl #(.IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .init_done (init_done),
    .bus       (bus),
    .arr_we    (arr_we),
    .arr_ix    (arr_ix),
    .arr_din   (arr_din),
    .arr_dout  (arr_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (arr_we) mem[arr_ix] <= arr_din;
  assign arr_dout = mem[arr_ix];

  task automatic set_req(input int id, input lru_op_t op, input logic [2:0] ix, input logic way);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_ix = ix; bus.req0_way = way;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_ix = ix; bus.req1_way = way;
    end
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({arr_we, arr_ix, arr_din, init_done, bus.req0_ready, bus.req1_ready} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_array_port: got %b want %b", {arr_we, arr_ix, arr_din, init_done, bus.req0_ready, bus.req1_ready}, 8'b1000_0000);
    end
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way} !== 3'b000) begin
      n_err++; $display("FAIL reset_rsp: got %b want 000", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({init_done, arr_we, arr_ix, arr_din} !== {1'b0, 1'b1, 3'(k), 1'b0}) begin
        n_err++; $display("FAIL init_sweep[%0d]: got %b want %b", k, {init_done, arr_we, arr_ix, arr_din}, {1'b0, 1'b1, 3'(k), 1'b0});
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({init_done, mem} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL init_done_array: got %b want %b", {init_done, mem}, {1'b1, 8'h00});
    end
  endtask

  task automatic test_touch();
    @(negedge clk);
    set_req(0, OP_TOUCH, 3'd3, 1'b0);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, arr_we, arr_ix, arr_din} !== {1'b1, 1'b0, 1'b1, 3'd3, 1'b1}) begin
      n_err++; $display("FAIL touch_grant: got %b want %b", {bus.req0_ready, bus.req1_ready, arr_we, arr_ix, arr_din}, {1'b1, 1'b0, 1'b1, 3'd3, 1'b1});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way, mem[3]} !== 4'b1001) begin
      n_err++; $display("FAIL touch_rsp: got %b want 1001", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way, mem[3]});
    end
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++;
    if ({bus.req0_ready, arr_we} !== 2'b00) begin
      n_err++; $display("FAIL idle_no_write: got %b want 00", {bus.req0_ready, arr_we});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      n_err++; $display("FAIL rsp_pulse_width: got %b want 00", {bus.rsp0_valid, bus.rsp1_valid});
    end
  endtask

  task automatic test_victim();
    @(negedge clk);
    set_req(1, OP_VICTIM, 3'd5, 1'b1);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, arr_ix, arr_din} !== {1'b0, 1'b1, 3'd5, 1'b1}) begin
      n_err++; $display("FAIL victim1_grant: got %b want %b", {bus.req0_ready, bus.req1_ready, arr_ix, arr_din}, {1'b0, 1'b1, 3'd5, 1'b1});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way, mem[5]} !== 4'b0101) begin
      n_err++; $display("FAIL victim1_rsp: got %b want 0101", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way, mem[5]});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.req1_ready, arr_din} !== 2'b10) begin
      n_err++; $display("FAIL victim2_grant: got %b want 10", {bus.req1_ready, arr_din});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp1_valid, bus.rsp_way, mem[5]} !== 3'b110) begin
      n_err++; $display("FAIL victim2_rsp: got %b want 110", {bus.rsp1_valid, bus.rsp_way, mem[5]});
    end
    @(negedge clk);
    clear_reqs();
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp1_valid, bus.rsp_way} !== 2'b01) begin
      n_err++; $display("FAIL rsp_way_hold: got %b want 01", {bus.rsp1_valid, bus.rsp_way});
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        set_req(0, OP_TOUCH, 3'd2, 1'b0);
        set_req(1, OP_TOUCH, 3'd6, 1'b1);
      end
      #1;
      n_cmp++;
      if ({bus.req1_ready, bus.req0_ready, arr_ix} !== ((c % 2 == 1) ? {2'b10, 3'd6} : {2'b01, 3'd2})) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", c, {bus.req1_ready, bus.req0_ready, arr_ix}, ((c % 2 == 1) ? {2'b10, 3'd6} : {2'b01, 3'd2}));
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_way} !== ((c % 2 == 1) ? 3'b101 : 3'b010)) begin
        n_err++; $display("FAIL rr_rsp[%0d]: got %b want %b", c, {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_way}, ((c % 2 == 1) ? 3'b101 : 3'b010));
      end
    end
    @(negedge clk);
    clear_reqs();
    n_cmp++;
    if ({mem[2], mem[6]} !== 2'b10) begin
      n_err++; $display("FAIL rr_array: got %b want 10", {mem[2], mem[6]});
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_req(0, OP_VICTIM, 3'd4, 1'b0);
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, arr_ix, arr_din} !== {1'b1, 3'd4, 1'b1}) begin
      n_err++; $display("FAIL flush_cycle_grant: got %b want %b", {bus.req0_ready, arr_ix, arr_din}, {1'b1, 3'd4, 1'b1});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp_way, mem[4], init_done} !== 4'b1010) begin
      n_err++; $display("FAIL flush_rsp: got %b want 1010", {bus.rsp0_valid, bus.rsp_way, mem[4], init_done});
    end
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      if (h == 0) begin
        clear_reqs();
        set_req(1, OP_TOUCH, 3'd7, 1'b0);
      end
      #1;
      n_cmp++;
      if ({init_done, bus.req0_ready, bus.req1_ready, arr_we, arr_ix} !== {4'b0001, 3'd0}) begin
        n_err++; $display("FAIL flush_hold[%0d]: got %b want %b", h, {init_done, bus.req0_ready, bus.req1_ready, arr_we, arr_ix}, {4'b0001, 3'd0});
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
        n_err++; $display("FAIL flush_no_rsp[%0d]: got %b want 00", h, {bus.rsp0_valid, bus.rsp1_valid});
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) flush = 1'b0;
      #1;
      n_cmp++;
      if ({init_done, bus.req1_ready, arr_we, arr_ix} !== {3'b001, 3'(k)}) begin
        n_err++; $display("FAIL flush_sweep[%0d]: got %b want %b", k, {init_done, bus.req1_ready, arr_we, arr_ix}, {3'b001, 3'(k)});
      end
    end
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++;
    if ({init_done, mem} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL flush_array_clear: got %b want %b", {init_done, mem}, {1'b1, 8'h00});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_req(0, OP_TOUCH, 3'd1, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp_way} !== 2'b11) begin
      n_err++; $display("FAIL pre_reset_rsp: got %b want 11", {bus.rsp0_valid, bus.rsp_way});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way, bus.req0_ready, init_done} !== 5'b00000) begin
      n_err++; $display("FAIL async_reset: got %b want 00000", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_way, bus.req0_ready, init_done});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({init_done, bus.req0_ready, arr_ix} !== {2'b00, 3'(k)}) begin
        n_err++; $display("FAIL post_reset_sweep[%0d]: got %b want %b", k, {init_done, bus.req0_ready, arr_ix}, {2'b00, 3'(k)});
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({init_done, bus.req0_ready, arr_ix, arr_din} !== {2'b11, 3'd1, 1'b0}) begin
      n_err++; $display("FAIL first_grant_after_reset: got %b want %b", {init_done, bus.req0_ready, arr_ix, arr_din}, {2'b11, 3'd1, 1'b0});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp_way} !== 2'b11) begin
      n_err++; $display("FAIL post_reset_rsp: got %b want 11", {bus.rsp0_valid, bus.rsp_way});
    end
    @(negedge clk);
    clear_reqs();
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = OP_TOUCH; bus.req0_ix = 3'd0; bus.req0_way = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_op = OP_TOUCH; bus.req1_ix = 3'd0; bus.req1_way = 1'b0;
    test_reset();
    test_touch();
    test_victim();
    test_back_to_back();
    test_flush();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
